// File: rtl/issue_pkg.sv
// Shared constants, types and the operand-read helper for the issue front end
// and the reservation stations it feeds.
package issue_pkg;

  localparam int NUM_RS   = 3;
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 3;
  localparam int REG_W    = 3;
  localparam int OP_W     = 3;

  localparam logic [TAG_W-1:0] NO_TAG = 3'd0;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } operand_t;

  // A producer broadcasting this very cycle is forwarded instead of being waited on.
  function automatic operand_t read_operand(
    input logic [TAG_W-1:0]  qi,
    input logic [DATA_W-1:0] rf,
    input logic              cdb_valid,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic [DATA_W-1:0] cdb_data
  );
    operand_t o;
    if (qi == NO_TAG) begin
      o.v = rf;
      o.q = NO_TAG;
    end else if (cdb_valid && (cdb_tag == qi)) begin
      o.v = cdb_data;
      o.q = NO_TAG;
    end else begin
      o.v = {DATA_W{1'b0}};
      o.q = qi;
    end
    return o;
  endfunction

endpackage

// File: rtl/reg_status_table.sv
// Architectural register file plus per-register producer tag (Qi), with
// two bypassed read ports, one rename port and associative CDB retirement.
module reg_status_table
  import issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_W-1:0]  rd_a_idx_i,
  input  logic [REG_W-1:0]  rd_b_idx_i,
  output operand_t          rd_a_o,
  output operand_t          rd_b_o,
  input  logic              ren_en_i,
  input  logic [REG_W-1:0]  ren_idx_i,
  input  logic [TAG_W-1:0]  ren_tag_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [TAG_W-1:0]  qi_q [NUM_REGS];
  logic [TAG_W-1:0]  qi_d [NUM_REGS];

  assign rd_a_o = read_operand(qi_q[rd_a_idx_i], rf_q[rd_a_idx_i], cdb_valid_i, cdb_tag_i, cdb_data_i);
  assign rd_b_o = read_operand(qi_q[rd_b_idx_i], rf_q[rd_b_idx_i], cdb_valid_i, cdb_tag_i, cdb_data_i);

  // CDB retires matching entries first; a rename of the same register overrides Qi.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rf_d[r] = rf_q[r];
      qi_d[r] = qi_q[r];
      if (cdb_valid_i && (cdb_tag_i != NO_TAG) && (qi_q[r] == cdb_tag_i)) begin
        rf_d[r] = cdb_data_i;
        qi_d[r] = NO_TAG;
      end else begin
        rf_d[r] = rf_q[r];
      end
      if (ren_en_i && (ren_idx_i == REG_W'(r))) begin
        qi_d[r] = ren_tag_i;
      end else begin
        qi_d[r] = qi_d[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        rf_q[r] <= {DATA_W{1'b0}};
        qi_q[r] <= NO_TAG;
      end
    end else begin
      rf_q <= rf_d;
      qi_q <= qi_d;
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Tomasulo issue stage: latches one instruction, allocates the lowest free
// reservation station and loads its operands, tracking busy state and stalls.
module issue_unit
  import issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [OP_W-1:0]   instr_opcode_i,
  input  logic [REG_W-1:0]  instr_rd_i,
  input  logic [REG_W-1:0]  instr_rs_i,
  input  logic [REG_W-1:0]  instr_rt_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  input  logic [NUM_RS-1:0] rs_done_i,
  output logic [NUM_RS-1:0] rs_enable_o,
  output logic [OP_W-1:0]   rs_opcode_o,
  output logic [DATA_W-1:0] rs_vj_o,
  output logic [DATA_W-1:0] rs_vk_o,
  output logic [TAG_W-1:0]  rs_qj_o,
  output logic [TAG_W-1:0]  rs_qk_o,
  output logic [NUM_RS-1:0] rs_busy_o,
  output logic [15:0]       stall_count_o
);

  state_e            state_q, state_d;
  logic              ready_q;
  logic              latch_en_s;
  logic [OP_W-1:0]   op_q;
  logic [REG_W-1:0]  rd_q, rs_q, rt_q;
  logic [NUM_RS-1:0] busy_q, busy_d;
  logic [NUM_RS-1:0] enable_q;
  logic [OP_W-1:0]   rs_opcode_q;
  logic [DATA_W-1:0] vj_q, vk_q;
  logic [TAG_W-1:0]  qj_q, qk_q;
  logic [15:0]       stall_q, stall_d;
  logic [NUM_RS-1:0] free_s, alloc_oh_s;
  logic [TAG_W-1:0]  alloc_tag_s;
  logic              alloc_s;
  operand_t          opj_s, opk_s;

  reg_status_table u_rst (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_a_idx_i  (rs_q),
    .rd_b_idx_i  (rt_q),
    .rd_a_o      (opj_s),
    .rd_b_o      (opk_s),
    .ren_en_i    (alloc_s),
    .ren_idx_i   (rd_q),
    .ren_tag_i   (alloc_tag_s),
    .cdb_valid_i (cdb_valid_i),
    .cdb_tag_i   (cdb_tag_i),
    .cdb_data_i  (cdb_data_i)
  );

  // Lowest-index free station wins; stations freed this cycle are not yet visible.
  always_comb begin
    free_s      = ~busy_q;
    alloc_oh_s  = {NUM_RS{1'b0}};
    alloc_tag_s = NO_TAG;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (free_s[i]) begin
        alloc_oh_s  = NUM_RS'(1) << i;
        alloc_tag_s = TAG_W'(i) + 3'd1;
      end else begin
        alloc_oh_s  = alloc_oh_s;
      end
    end
    alloc_s = (state_q == DISPATCH) && (|free_s);
  end

  always_comb begin
    state_d    = state_q;
    latch_en_s = 1'b0;
    stall_d    = stall_q;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          state_d    = DISPATCH;
          latch_en_s = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      DISPATCH: begin
        if (alloc_s) begin
          state_d = IDLE;
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end else begin
          stall_d = stall_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (busy_q & ~rs_done_i) | (alloc_s ? alloc_oh_s : {NUM_RS{1'b0}});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      op_q        <= 3'd0;
      rd_q        <= 3'd0;
      rs_q        <= 3'd0;
      rt_q        <= 3'd0;
      busy_q      <= {NUM_RS{1'b0}};
      enable_q    <= {NUM_RS{1'b0}};
      rs_opcode_q <= 3'd0;
      vj_q        <= 16'd0;
      vk_q        <= 16'd0;
      qj_q        <= NO_TAG;
      qk_q        <= NO_TAG;
      stall_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == IDLE);
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      enable_q <= alloc_s ? alloc_oh_s : {NUM_RS{1'b0}};
      if (latch_en_s) begin
        op_q <= instr_opcode_i;
        rd_q <= instr_rd_i;
        rs_q <= instr_rs_i;
        rt_q <= instr_rt_i;
      end
      if (alloc_s) begin
        rs_opcode_q <= op_q;
        vj_q        <= opj_s.v;
        qj_q        <= opj_s.q;
        vk_q        <= opk_s.v;
        qk_q        <= opk_s.q;
      end
    end
  end

  assign instr_ready_o = ready_q;
  assign rs_enable_o   = enable_q;
  assign rs_opcode_o   = rs_opcode_q;
  assign rs_vj_o       = vj_q;
  assign rs_vk_o       = vk_q;
  assign rs_qj_o       = qj_q;
  assign rs_qk_o       = qk_q;
  assign rs_busy_o     = busy_q;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: allocation, dependencies, CDB bypass,
// full-station stalls, rename/CDB collision and asynchronous reset.
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_opcode, instr_rd, instr_rs, instr_rt;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  rs_done;
  logic [2:0]  rs_enable;
  logic [2:0]  rs_opcode;
  logic [15:0] rs_vj, rs_vk;
  logic [2:0]  rs_qj, rs_qk;
  logic [2:0]  rs_busy;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_unit dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_opcode_i (instr_opcode),
    .instr_rd_i     (instr_rd),
    .instr_rs_i     (instr_rs),
    .instr_rt_i     (instr_rt),
    .cdb_valid_i    (cdb_valid),
    .cdb_tag_i      (cdb_tag),
    .cdb_data_i     (cdb_data),
    .rs_done_i      (rs_done),
    .rs_enable_o    (rs_enable),
    .rs_opcode_o    (rs_opcode),
    .rs_vj_o        (rs_vj),
    .rs_vk_o        (rs_vk),
    .rs_qj_o        (rs_qj),
    .rs_qk_o        (rs_qk),
    .rs_busy_o      (rs_busy),
    .stall_count_o  (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(instr_ready), 32'd1);
    check({tag, "_enable"}, 32'(rs_enable),   32'd0);
    check({tag, "_busy"},   32'(rs_busy),     32'd0);
    check({tag, "_stall"},  32'(stall_count), 32'd0);
    check({tag, "_opcode"}, 32'(rs_opcode),   32'd0);
    check({tag, "_vj"},     32'(rs_vj),       32'd0);
    check({tag, "_vk"},     32'(rs_vk),       32'd0);
    check({tag, "_qj"},     32'(rs_qj),       32'd0);
    check({tag, "_qk"},     32'(rs_qk),       32'd0);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after allocation.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic cv, input logic [2:0] ct,
                       input logic [15:0] cd);
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_rd     = rd;
    instr_rs     = rs;
    instr_rt     = rt;
    @(negedge clk);
    instr_valid = 1'b0;
    cdb_valid   = cv;
    cdb_tag     = ct;
    cdb_data    = cd;
    @(negedge clk);
    cdb_valid = 1'b0;
    cdb_tag   = 3'd0;
    cdb_data  = 16'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_opcode = 3'd0; instr_rd = 3'd0;
    instr_rs = 3'd0; instr_rt = 3'd0; cdb_valid = 1'b0; cdb_tag = 3'd0;
    cdb_data = 16'd0; rs_done = 3'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First issue: op 1, rd=2, rs=0, rt=1
    instr_valid = 1'b1; instr_opcode = 3'd1; instr_rd = 3'd2; instr_rs = 3'd0; instr_rt = 3'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("t1_ready_low", 32'(instr_ready), 32'd0);
    check("t1_en_pre",    32'(rs_enable),   32'd0);
    @(negedge clk);
    check("t1_enable", 32'(rs_enable), 32'd1);
    check("t1_opcode", 32'(rs_opcode), 32'd1);
    check("t1_qj",     32'(rs_qj),     32'd0);
    check("t1_qk",     32'(rs_qk),     32'd0);
    check("t1_vj",     32'(rs_vj),     32'd0);
    check("t1_vk",     32'(rs_vk),     32'd0);
    check("t1_busy",   32'(rs_busy),   32'd1);
    check("t1_ready",  32'(instr_ready), 32'd1);
    check("t1_qi2",    32'(dut.u_rst.qi_q[2]), 32'd1);
    @(negedge clk);
    check("t1_enable_drop", 32'(rs_enable), 32'd0);

    // Dependency on r2 (producer tag 1), no CDB
    issue(3'd2, 3'd4, 3'd2, 3'd0, 1'b0, 3'd0, 16'd0);
    check("t2_enable", 32'(rs_enable), 32'd2);
    check("t2_qj",     32'(rs_qj),     32'd1);
    check("t2_vj",     32'(rs_vj),     32'd0);
    check("t2_qk",     32'(rs_qk),     32'd0);
    check("t2_busy",   32'(rs_busy),   32'd3);

    // Same dependency, but tag 1 broadcasts in the allocation cycle
    issue(3'd3, 3'd5, 3'd2, 3'd4, 1'b1, 3'd1, 16'h00AB);
    check("t3_enable", 32'(rs_enable), 32'd4);
    check("t3_qj",     32'(rs_qj),     32'd0);
    check("t3_vj",     32'(rs_vj),     32'h00AB);
    check("t3_qk",     32'(rs_qk),     32'd2);
    check("t3_vk",     32'(rs_vk),     32'd0);
    check("t3_rf2",    32'(dut.u_rst.rf_q[2]), 32'h00AB);
    check("t3_qi2",    32'(dut.u_rst.qi_q[2]), 32'd0);

    // Fourth instruction with all stations busy
    instr_valid = 1'b1; instr_opcode = 3'd4; instr_rd = 3'd6; instr_rs = 3'd2; instr_rt = 3'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("t4_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("t4_stall1", 32'(stall_count), 32'd1);
    check("t4_en_none", 32'(rs_enable), 32'd0);
    @(negedge clk);
    check("t4_stall2", 32'(stall_count), 32'd2);
    check("t4_ready_hold", 32'(instr_ready), 32'd0);
    rs_done = 3'b010;
    @(negedge clk);
    rs_done = 3'b000;
    check("t4_stall3", 32'(stall_count), 32'd3);
    check("t4_busy_freed", 32'(rs_busy), 32'd5);
    check("t4_no_bypass_en", 32'(rs_enable), 32'd0);
    @(negedge clk);
    check("t4_enable", 32'(rs_enable), 32'd2);
    check("t4_opcode", 32'(rs_opcode), 32'd4);
    check("t4_vj",     32'(rs_vj),     32'h00AB);
    check("t4_qj",     32'(rs_qj),     32'd0);
    check("t4_busy",   32'(rs_busy),   32'd7);
    check("t4_stall_hold", 32'(stall_count), 32'd3);
    check("t4_ready",  32'(instr_ready), 32'd1);

    // Free stations 0 and 2, set Qi[3]=1, then rename r3 while tag 1 broadcasts
    rs_done = 3'b101;
    @(negedge clk);
    rs_done = 3'b000;
    check("t5_busy", 32'(rs_busy), 32'd2);
    issue(3'd5, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 16'd0);
    check("t5_enable", 32'(rs_enable), 32'd1);
    check("t5_qi3",    32'(dut.u_rst.qi_q[3]), 32'd1);
    issue(3'd6, 3'd3, 3'd3, 3'd7, 1'b1, 3'd1, 16'h1234);
    check("t6_enable", 32'(rs_enable), 32'd4);
    check("t6_vj",     32'(rs_vj),     32'h1234);
    check("t6_qj",     32'(rs_qj),     32'd0);
    check("t6_rf3",    32'(dut.u_rst.rf_q[3]), 32'h1234);
    check("t6_qi3",    32'(dut.u_rst.qi_q[3]), 32'd3);

    // A tag-0 broadcast must not touch ready registers
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'hFFFF;
    @(negedge clk);
    cdb_valid = 1'b0; cdb_data = 16'd0;
    check("t7_rf0", 32'(dut.u_rst.rf_q[0]), 32'd0);
    check("t7_rf1", 32'(dut.u_rst.rf_q[1]), 32'd0);

    // Reset while stalled in DISPATCH
    instr_valid = 1'b1; instr_opcode = 3'd7; instr_rd = 3'd1; instr_rs = 3'd0; instr_rt = 3'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("t8_stall_pre", 32'(stall_count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t8_async");
    @(negedge clk);
    rst_n = 1'b1;
    check("t8_rf3_clr", 32'(dut.u_rst.rf_q[3]), 32'd0);
    issue(3'd1, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'd0);
    check("t8_enable", 32'(rs_enable), 32'd1);
    check("t8_opcode", 32'(rs_opcode), 32'd1);
    check("t8_vj",     32'(rs_vj),     32'd0);
    check("t8_qk",     32'(rs_qk),     32'd0);
    check("t8_qi1",    32'(dut.u_rst.qi_q[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

Front end of the Tomasulo datapath: accepts one decoded instruction at a time, allocates a free R-type reservation station, and drives that station's operand-load interface (Opcode, Vj/Vk, Qj/Qk, one-hot Enable_VQ). It owns the architectural register file and the register status table (Qi per register), snoops the common data bus (CDB) to retire results, and tracks station occupancy from station release pulses.

## Interface
- NUM_RS, 3: number of reservation stations; station i has tag i+1, and tag 0 means no dependency.
- NUM_REGS, 8: architectural registers.
- DATA_W, 16: operand/result width.
- TAG_W, 3: tag width; must satisfy NUM_RS+1 <= 2**TAG_W.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr_valid  in  1  instruction offered.
- Instr_ready  out  1  unit can accept an instruction.
- Instr_opcode  in  3  operation, passed through to the station.
- Instr_rd, Instr_rs, Instr_rt  in  3 each  destination and source register indices.
- Cdb_valid  in  1  CDB broadcast valid.
- Cdb_tag  in  TAG_W  producing station tag.
- Cdb_data  in  DATA_W  broadcast result.
- Rs_done  in  NUM_RS  one-cycle pulse per station when it frees itself.
- Rs_enable  out  NUM_RS  one-hot, one-cycle load strobe to the Enable_VQ input of each station.
- Rs_opcode  out  3  opcode for the loaded station.
- Rs_vj, Rs_vk  out  DATA_W  operand values; 0 when the matching Q is nonzero.
- Rs_qj, Rs_qk  out  TAG_W  producer tags; 0 when the value is valid.
- Rs_busy  out  NUM_RS  station occupancy vector.
- Stall_count  out  16  saturating count of DISPATCH cycles with no free station.

## Operation
- FSM states IDLE and DISPATCH.
  - IDLE: Instr_ready=1. On Instr_valid, latch opcode, rd, rs, and rt, then go to DISPATCH.
  - DISPATCH: Instr_ready=0. If any Rs_busy bit is 0, allocate the lowest-index free station k, then go to IDLE. Otherwise stay in DISPATCH and increment Stall_count, saturating at 16'hFFFF.
- Operand read for source s, using Qi and RF values at the start of the cycle:
  - Qi[s]==0: V=RF[s], Q=0.
  - Cdb_valid and Cdb_tag==Qi[s]: V=Cdb_data, Q=0 (CDB bypass).
  - Otherwise: V=0, Q=Qi[s].
- On allocation, register the operand results into the Rs_* outputs, set Rs_enable[k], set busy[k], and write Qi[rd]=k+1.
- Rs_enable is registered and cleared on every cycle without an allocation. Rs_opcode, Rs_v* and Rs_q* hold their last values.
- CDB update: for every register r with Qi[r]==Cdb_tag!=0, write RF[r]=Cdb_data and Qi[r]=0.
- Rs_done[i] clears busy[i].
- Simultaneous events:
  - Rename wins over CDB clear on Qi[rd]. RF[rd] still takes Cdb_data if the old Qi matched.
  - rs or rt == rd: sources read the pre-rename Qi.
  - Rs_done and allocation in the same cycle: the freed station is not eligible until the next cycle. No busy bypass.
  - Cdb_tag==0 is ignored.
- Reset mid-DISPATCH drops the latched instruction.

## Timing
- Reset values: state IDLE, Instr_ready=1, RF all 0, Qi all 0, busy 0, Rs_enable 0, Rs_opcode 0, Rs_v* 0, Rs_q* 0, Stall_count 0.
- Latency, with a free station: accept at edge e0, allocate at e1, Rs_enable high for the one cycle after e1. Instr_ready is high again in that same cycle.
- Peak throughput is one instruction per 2 cycles.
- Instr_ready depends only on state, never combinationally on Instr_valid.
- A CDB broadcast at edge e updates RF and Qi visibly after e. The bypass covers a broadcast in the allocation cycle itself.

## Structure
- Package issue_pkg:
  - TAG_W and NO_TAG=0.
  - FSM state enum {IDLE, DISPATCH}.
  - Opcode constants shared with the stations and functional units.
- Sub-module reg_status_table:
  - Contents: NUM_REGS x DATA_W values plus NUM_REGS x TAG_W Qi.
  - Ports: two combinational read ports with CDB bypass, one rename write port, CDB associative update, asynchronous active-low reset.
- issue_unit top: FSM, instruction latch, free-station priority encoder, busy vector, output registers, stall counter.

## Test plan
- Reset, then issue opcode 1, rd=2, rs=0, rt=1 -> Rs_enable=3'b001 exactly one cycle, Rs_qj=Rs_qk=0, Rs_vj=Rs_vk=0, Qi[2]=1, Rs_busy=3'b001.
- Dependency and bypass:
  - Issue rd=2, then rs=2 with no CDB -> second load has Rs_qj=1, Rs_vj=0, Rs_enable=3'b010.
  - Repeat with Cdb_valid, tag 1, data 16'h00AB in the allocation cycle -> Rs_qj=0, Rs_vj=16'h00AB.
- Full stations: issue 4 instructions with no Rs_done -> 4th holds in DISPATCH, Instr_ready=0, Stall_count increments each cycle. Pulse Rs_done=3'b010 -> next cycle allocates station 1 with Rs_enable=3'b010.
- Rename vs CDB: Qi[3]=1; same cycle, CDB tag 1 data 16'h1234 and allocation of station 2 with rd=3 -> RF[3]=16'h1234, Qi[3]=3.
- Reset asserted mid-DISPATCH -> all outputs at reset values immediately, with no clock needed. Later reissue allocates station 0.
